// File: rtl/fpu_half_decode.sv
// Half-precision FP decode stage: 1-cycle registered decode, output reg + 1 skid entry.
// Optional FLH/FSH decode enabled by defining FPU_HALF_LDST_EN.
module fpu_half_decode #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned OPSEL_W = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               flush,
    input  logic               frm_we,
    input  logic [2:0]         frm_wdata,
    output logic [2:0]         frm,
    input  logic               instr_valid,
    input  logic [WORD_W-1:0]  instr,
    output logic               instr_ready,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [OPSEL_W-1:0] dec_op,
    output logic [4:0]         dec_rd,
    output logic [4:0]         dec_rs1,
    output logic [4:0]         dec_rs2,
    output logic [4:0]         dec_rs3,
    output logic [2:0]         dec_rm,
    output logic [11:0]        dec_imm,
    output logic               dec_illegal
);

    typedef struct packed {
        logic [OPSEL_W-1:0] op;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rs3;
        logic [2:0]         rm;
        logic [11:0]        imm;
        logic               illegal;
    } bundle_t;

    localparam logic [6:0] OpcFop    = 7'b1010011;
    localparam logic [6:0] OpcFmadd  = 7'b1000011;
    localparam logic [6:0] OpcFmsub  = 7'b1000111;
    localparam logic [6:0] OpcFnmsub = 7'b1001011;
    localparam logic [6:0] OpcFnmadd = 7'b1001111;
    localparam logic [6:0] OpcFload  = 7'b0000111;
    localparam logic [6:0] OpcFstore = 7'b0100111;

    bundle_t    out_q, out_d, skid_q, skid_d, dec_n;
    logic       out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [2:0] frm_q, frm_d;

    logic [6:0]         opcode;
    logic [4:0]         funct5;
    logic [1:0]         fmt;
    logic [2:0]         rm_f;
    logic [4:0]         rs2_f;
    logic [2:0]         rm_res;
    logic               rounding;
    logic               legal;
    logic [OPSEL_W-1:0] op_n;
    logic [11:0]        imm_n;
    logic               rd_zero;
    logic               accept;
    logic               issue;

    // Combinational decode of the incoming word against the current frm CSR.
    always_comb begin
        opcode   = instr[6:0];
        funct5   = instr[31:27];
        fmt      = instr[26:25];
        rm_f     = instr[14:12];
        rs2_f    = instr[24:20];
        rm_res   = (rm_f == 3'b111) ? frm_q : rm_f;
        rounding = 1'b0;
        legal    = 1'b0;
        op_n     = '0;
        imm_n    = '0;
        rd_zero  = 1'b0;
        dec_n    = '0;
        dec_n.rd  = instr[11:7];
        dec_n.rs1 = instr[19:15];
        dec_n.rs2 = rs2_f;

        case (opcode)
            OpcFop: begin
                if (fmt == 2'b10) begin
                    case (funct5)
                        5'b00000: begin legal = 1'b1; rounding = 1'b1; op_n = OPSEL_W'(0); end
                        5'b00001: begin legal = 1'b1; rounding = 1'b1; op_n = OPSEL_W'(1); end
                        5'b00010: begin legal = 1'b1; rounding = 1'b1; op_n = OPSEL_W'(2); end
                        5'b00011: begin legal = 1'b1; rounding = 1'b1; op_n = OPSEL_W'(3); end
                        5'b01011: begin
                            legal    = (rs2_f == 5'd0);
                            rounding = 1'b1;
                            op_n     = OPSEL_W'(4);
                        end
                        5'b00100: begin
                            legal = (rm_f <= 3'b010);
                            op_n  = OPSEL_W'(5 + int'(rm_f[1:0]));
                        end
                        5'b00101: begin
                            legal = (rm_f <= 3'b001);
                            op_n  = OPSEL_W'(8 + int'(rm_f[0]));
                        end
                        5'b10100: begin
                            legal = (rm_f <= 3'b010);
                            // rm 010/001/000 map to FEQ/FLT/FLE
                            op_n  = OPSEL_W'(12 - int'(rm_f[1:0]));
                        end
                        5'b11100: begin
                            legal = (rm_f == 3'b001) && (rs2_f == 5'd0);
                            op_n  = OPSEL_W'(13);
                        end
                        default: legal = 1'b0;
                    endcase
                end
            end
            OpcFmadd, OpcFmsub, OpcFnmsub, OpcFnmadd: begin
                legal     = (fmt == 2'b10);
                rounding  = 1'b1;
                op_n      = OPSEL_W'(14 + int'(opcode[3:2]));
                dec_n.rs3 = instr[31:27];
            end
`ifdef FPU_HALF_LDST_EN
            OpcFload: begin
                legal = (rm_f == 3'b001);
                op_n  = OPSEL_W'(18);
                imm_n = instr[31:20];
            end
            OpcFstore: begin
                legal   = (rm_f == 3'b001);
                op_n    = OPSEL_W'(19);
                imm_n   = {instr[31:25], instr[11:7]};
                rd_zero = 1'b1;
            end
`else
            OpcFload, OpcFstore: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase

        // Reserved resolved modes (static 101/110 or dynamic frm >= 101) only matter when rounding
        if (rounding && (rm_res >= 3'b101)) begin
            legal = 1'b0;
        end

        if (legal) begin
            dec_n.op  = op_n;
            dec_n.rm  = rounding ? rm_res : 3'b000;
            dec_n.imm = imm_n;
            if (rd_zero) begin
                dec_n.rd = 5'd0;
            end
        end else begin
            dec_n.illegal = 1'b1;
        end
    end

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        frm_d        = frm_we ? frm_wdata : frm_q;
        accept       = instr_valid && !skid_valid_q;
        issue        = out_valid_q && dec_ready;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (issue) begin
                out_valid_d = 1'b0;
            end
            if (skid_valid_q) begin
                if (issue) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (!out_valid_q || issue) begin
                    out_d       = dec_n;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = dec_n;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            frm_q        <= 3'b000;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            frm_q        <= frm_d;
        end
    end

    assign frm         = frm_q;
    assign instr_ready = !skid_valid_q;
    assign dec_valid   = out_valid_q;
    assign dec_op      = out_q.op;
    assign dec_rd      = out_q.rd;
    assign dec_rs1     = out_q.rs1;
    assign dec_rs2     = out_q.rs2;
    assign dec_rs3     = out_q.rs3;
    assign dec_rm      = out_q.rm;
    assign dec_imm     = out_q.imm;
    assign dec_illegal = out_q.illegal;

endmodule
